// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: widths, ALUFun codes and
// the arbiter FSM state encoding.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int FUN_W = 6;

    localparam logic [FUN_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [FUN_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [FUN_W-1:0] ALU_EQ  = 6'b110011;
    localparam logic [FUN_W-1:0] ALU_NEQ = 6'b110001;
    localparam logic [FUN_W-1:0] ALU_LT  = 6'b110101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and
// the branch-resolution unit (requester 1), one transaction at a time.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int FUN_W_P = FUN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [WIDTH_P-1:0] r0_a,
    input  logic [WIDTH_P-1:0] r0_b,
    input  logic [FUN_W_P-1:0] r0_fun,
    input  logic               r0_sign,
    output logic               r0_rvalid,
    input  logic               r0_rready,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [WIDTH_P-1:0] r1_a,
    input  logic [WIDTH_P-1:0] r1_b,
    input  logic [FUN_W_P-1:0] r1_fun,
    input  logic               r1_sign,
    output logic               r1_rvalid,
    input  logic               r1_rready,
    output logic [WIDTH_P-1:0] r_data,
    output logic [WIDTH_P-1:0] alu_a,
    output logic [WIDTH_P-1:0] alu_b,
    output logic [FUN_W_P-1:0] alu_fun,
    output logic               alu_sign,
    input  logic [WIDTH_P-1:0] alu_s,
    output logic               busy,
    output state_e             state_dbg
);

    // Handshakes: a request transfers on a clock edge where rN_valid and
    // rN_ready are both high; a response transfers where rN_rvalid and
    // rN_rready are both high. Ready is only offered in IDLE, to one winner.

    state_e             state_q, state_d;
    logic               winner_q, winner_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH_P-1:0] a_q, a_d;
    logic [WIDTH_P-1:0] b_q, b_d;
    logic [FUN_W_P-1:0] fun_q, fun_d;
    logic               sign_q, sign_d;
    logic [WIDTH_P-1:0] r_data_q, r_data_d;
    logic [1:0]         gnt;

    rr_arb2 u_arb (
        .req_i        ({r1_valid, r0_valid}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            fun_q        <= '0;
            sign_q       <= 1'b0;
            r_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            fun_q        <= fun_d;
            sign_q       <= sign_d;
            r_data_q     <= r_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        fun_d        = fun_q;
        sign_d       = sign_q;
        r_data_d     = r_data_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        case (state_q)
            IDLE: begin
                r0_ready = gnt[0];
                r1_ready = gnt[1];
                if (|gnt) begin
                    winner_d     = gnt[1];
                    last_grant_d = gnt[1];
                    a_d          = gnt[1] ? r1_a    : r0_a;
                    b_d          = gnt[1] ? r1_b    : r0_b;
                    fun_d        = gnt[1] ? r1_fun  : r0_fun;
                    sign_d       = gnt[1] ? r1_sign : r0_sign;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                r_data_d = alu_s;
                state_d  = RESP;
            end
            RESP: begin
                // Only the winner's rready can close the transaction.
                if (winner_q ? r1_rready : r0_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ALU inputs stay at zero outside ISSUE so the shared ALU does not toggle.
    assign alu_a     = (state_q == ISSUE) ? a_q    : '0;
    assign alu_b     = (state_q == ISSUE) ? b_q    : '0;
    assign alu_fun   = (state_q == ISSUE) ? fun_q  : '0;
    assign alu_sign  = (state_q == ISSUE) ? sign_q : 1'b0;

    assign r0_rvalid = (state_q == RESP) && !winner_q;
    assign r1_rvalid = (state_q == RESP) &&  winner_q;
    assign r_data    = r_data_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU model and
// a response scoreboard.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic             clk;
    logic             reset;
    logic             r0_valid, r0_ready, r0_sign, r0_rvalid, r0_rready;
    logic [WIDTH-1:0] r0_a, r0_b;
    logic [FUN_W-1:0] r0_fun;
    logic             r1_valid, r1_ready, r1_sign, r1_rvalid, r1_rready;
    logic [WIDTH-1:0] r1_a, r1_b;
    logic [FUN_W-1:0] r1_fun;
    logic [WIDTH-1:0] r_data, alu_a, alu_b, alu_s;
    logic [FUN_W-1:0] alu_fun;
    logic             alu_sign, busy;
    state_e           state_dbg;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_id_q[$];
    int               n_cmp;
    int               n_err;

    alu_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r0_fun    (r0_fun),
        .r0_sign   (r0_sign),
        .r0_rvalid (r0_rvalid),
        .r0_rready (r0_rready),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .r1_fun    (r1_fun),
        .r1_sign   (r1_sign),
        .r1_rvalid (r1_rvalid),
        .r1_rready (r1_rready),
        .r_data    (r_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_sign  (alu_sign),
        .alu_s     (alu_s),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_model(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [FUN_W-1:0] fun,
                                                   input logic sign);
        logic bit_r;
        case (fun)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_EQ:  bit_r = (a == b);
            ALU_NEQ: bit_r = (a != b);
            ALU_LT:  bit_r = sign ? ($signed(a) < $signed(b)) : (a < b);
            default: return a ^ b;
        endcase
        return {{(WIDTH-1){1'b0}}, bit_r};
    endfunction

    assign alu_s = alu_model(alu_a, alu_b, alu_fun, alu_sign);

    // ---------------- driver tasks ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Sample point: scoreboard retires any response handshake seen this cycle.
    task automatic smp();
        logic [WIDTH-1:0] e;
        logic             id;
        @(negedge clk);
        if (!reset) begin
            if (r0_rvalid && r0_rready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL resp0_unexpected: got data=%h, required no response", r_data);
                end else begin
                    e  = exp_q.pop_front();
                    id = exp_id_q.pop_front();
                    if (r_data !== e || id !== 1'b0) begin
                        n_err++;
                        $display("FAIL resp0: got id=0 data=%h, required id=%0d data=%h", r_data, id, e);
                    end
                end
            end
            if (r1_rvalid && r1_rready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL resp1_unexpected: got data=%h, required no response", r_data);
                end else begin
                    e  = exp_q.pop_front();
                    id = exp_id_q.pop_front();
                    if (r_data !== e || id !== 1'b1) begin
                        n_err++;
                        $display("FAIL resp1: got id=1 data=%h, required id=%0d data=%h", r_data, id, e);
                    end
                end
            end
        end
    endtask

    task automatic rand_req(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b,
                            output logic [FUN_W-1:0] fun, output logic sign);
        a    = $urandom;
        b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
        sign = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0:       fun = ALU_ADD;
            1:       fun = ALU_SUB;
            2:       fun = ALU_EQ;
            3:       fun = ALU_NEQ;
            default: fun = ALU_LT;
        endcase
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) begin
            adv();
            smp();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, exp_q.size());
        end
        adv();
        smp();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
        smp();
        n_cmp++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy, alu_sign} !== 6'b0 ||
            r_data !== '0 || alu_a !== '0 || alu_b !== '0 || alu_fun !== '0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b%b rv=%b%b busy=%b r_data=%h alu_a=%h state=%0d, required all 0",
                     r1_ready, r0_ready, r1_rvalid, r0_rvalid, busy, r_data, alu_a, state_dbg);
        end
    endtask

    task automatic test_single();
        adv();
        r0_a = 32'd5; r0_b = 32'd7; r0_fun = ALU_SUB; r0_sign = 1'b1;
        r0_valid = 1'b1; r0_rready = 1'b1;
        smp();
        n_cmp++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0 || alu_a !== '0 || alu_fun !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: got rdy0=%b rdy1=%b alu_a=%h busy=%b, required 1 0 0 0",
                     r0_ready, r1_ready, alu_a, busy);
        end
        exp_q.push_back(32'hFFFF_FFFE);
        exp_id_q.push_back(1'b0);
        adv();
        r0_valid = 1'b0;
        smp();
        n_cmp++;
        if (state_dbg !== ISSUE || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_fun !== ALU_SUB ||
            alu_sign !== 1'b1 || r0_ready !== 1'b0 || r0_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL single_issue: got state=%0d alu=%h/%h/%b/%b rdy0=%b rv0=%b, required ISSUE 5/7/SUB/1 0 0",
                     state_dbg, alu_a, alu_b, alu_fun, alu_sign, r0_ready, r0_rvalid);
        end
        adv();
        smp();
        n_cmp++;
        if (r0_rvalid !== 1'b1 || r_data !== 32'hFFFF_FFFE || alu_a !== '0 || alu_fun !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_resp: got rv0=%b r_data=%h alu_a=%h busy=%b, required 1 fffffffe 0 1",
                     r0_rvalid, r_data, alu_a, busy);
        end
        adv();
        smp();
        n_cmp++;
        if (busy !== 1'b0 || r0_rvalid !== 1'b0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL single_done: got busy=%b rv0=%b state=%0d, required 0 0 IDLE", busy, r0_rvalid, state_dbg);
        end
    endtask

    task automatic test_tie_after_reset();
        adv();
        reset = 1'b1;
        adv();
        reset = 1'b0;
        r0_a = 32'd3; r0_b = 32'd3; r0_fun = ALU_EQ; r0_sign = 1'b0;
        r1_a = 32'hFFFF_FFFF; r1_b = 32'd0; r1_fun = ALU_LT; r1_sign = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1; r0_rready = 1'b1; r1_rready = 1'b1;
        smp();
        n_cmp++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL tie_first: got rdy0=%b rdy1=%b, required 1 0", r0_ready, r1_ready);
        end
        exp_q.push_back(32'd1);
        exp_id_q.push_back(1'b0);
        adv();
        r0_valid = 1'b0;
        smp();
        adv();
        smp();
        n_cmp++;
        if (r0_rvalid !== 1'b1 || r_data !== 32'd1) begin
            n_err++;
            $display("FAIL tie_resp0: got rv0=%b r_data=%h, required 1 00000001", r0_rvalid, r_data);
        end
        adv();
        smp();
        n_cmp++;
        if (r1_ready !== 1'b1 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL tie_second: got rdy1=%b state=%0d, required 1 IDLE", r1_ready, state_dbg);
        end
        exp_q.push_back(32'd1);
        exp_id_q.push_back(1'b1);
        adv();
        r1_valid = 1'b0;
        smp();
        adv();
        smp();
        n_cmp++;
        if (r1_rvalid !== 1'b1 || r_data !== 32'd1) begin
            n_err++;
            $display("FAIL tie_resp1: got rv1=%b r_data=%h, required 1 00000001", r1_rvalid, r_data);
        end
        adv();
        smp();
        n_cmp++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL tie_six_cycles: got busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_contention();
        logic acc0, acc1;
        logic glog[$];
        acc0 = 1'b0;
        acc1 = 1'b0;
        adv();
        rand_req(r0_a, r0_b, r0_fun, r0_sign);
        rand_req(r1_a, r1_b, r1_fun, r1_sign);
        r0_valid = 1'b1; r1_valid = 1'b1; r0_rready = 1'b1; r1_rready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) adv();
            if (acc0) rand_req(r0_a, r0_b, r0_fun, r0_sign);
            if (acc1) rand_req(r1_a, r1_b, r1_fun, r1_sign);
            smp();
            acc0 = r0_ready;
            acc1 = r1_ready;
            n_cmp++;
            if (r0_ready && r1_ready) begin
                n_err++;
                $display("FAIL contention_both_ready: got both ready in cycle %0d, required at most one", c);
            end
            if (r0_ready) begin
                exp_q.push_back(alu_model(r0_a, r0_b, r0_fun, r0_sign));
                exp_id_q.push_back(1'b0);
                glog.push_back(1'b0);
            end
            if (r1_ready) begin
                exp_q.push_back(alu_model(r1_a, r1_b, r1_fun, r1_sign));
                exp_id_q.push_back(1'b1);
                glog.push_back(1'b1);
            end
        end
        adv();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        smp();
        drain("contention");
        n_cmp++;
        if (glog.size() != 4) begin
            n_err++;
            $display("FAIL contention_count: got %0d grants, required 4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (glog[i] !== 1'(i % 2)) begin
                    n_err++;
                    $display("FAIL contention_order: got grant[%0d]=%0d, required %0d", i, glog[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] hold;
        adv();
        rand_req(r1_a, r1_b, r1_fun, r1_sign);
        r1_valid = 1'b1; r1_rready = 1'b0; r0_rready = 1'b1;
        smp();
        n_cmp++;
        if (r1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: got rdy1=%b, required 1", r1_ready);
        end
        hold = alu_model(r1_a, r1_b, r1_fun, r1_sign);
        exp_q.push_back(hold);
        exp_id_q.push_back(1'b1);
        adv();
        r1_valid = 1'b0;
        rand_req(r0_a, r0_b, r0_fun, r0_sign);
        r0_valid = 1'b1;
        smp();
        for (int i = 0; i < 4; i++) begin
            adv();
            smp();
            n_cmp++;
            if (state_dbg !== RESP || r1_rvalid !== 1'b1 || r_data !== hold || r0_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: got state=%0d rv1=%b r_data=%h rdy0=%b, required RESP 1 %h 0",
                         state_dbg, r1_rvalid, r_data, r0_ready, hold);
            end
        end
        adv();
        r1_rready = 1'b1;
        smp();
        n_cmp++;
        if (r0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rdy0=%b in rready cycle, required 0", r0_ready);
        end
        adv();
        smp();
        n_cmp++;
        if (r0_ready !== 1'b1 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL bp_after: got rdy0=%b state=%0d, required 1 IDLE", r0_ready, state_dbg);
        end
        exp_q.push_back(alu_model(r0_a, r0_b, r0_fun, r0_sign));
        exp_id_q.push_back(1'b0);
        adv();
        r0_valid = 1'b0;
        smp();
        drain("bp");
    endtask

    task automatic test_reset_mid_issue();
        adv();
        rand_req(r1_a, r1_b, r1_fun, r1_sign);
        r1_a = r1_a | 32'h1;
        r1_valid = 1'b1;
        smp();
        n_cmp++;
        if (r1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_accept: got rdy1=%b, required 1", r1_ready);
        end
        adv();
        r1_valid = 1'b0;
        reset = 1'b1;
        smp();
        n_cmp++;
        if (state_dbg !== ISSUE) begin
            n_err++;
            $display("FAIL rst_in_issue: got state=%0d, required ISSUE", state_dbg);
        end
        adv();
        reset = 1'b0;
        smp();
        n_cmp++;
        if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid, busy, alu_sign} !== 6'b0 ||
            r_data !== '0 || alu_a !== '0 || alu_b !== '0 || alu_fun !== '0 || state_dbg !== IDLE) begin
            n_err++;
            $display("FAIL rst_outputs: got rv=%b%b busy=%b r_data=%h alu_a=%h state=%0d, required all 0",
                     r1_rvalid, r0_rvalid, busy, r_data, alu_a, state_dbg);
        end
        adv();
        smp();
        n_cmp++;
        if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_resp: got rv=%b%b, required 00", r1_rvalid, r0_rvalid);
        end
        adv();
        rand_req(r0_a, r0_b, r0_fun, r0_sign);
        rand_req(r1_a, r1_b, r1_fun, r1_sign);
        r0_valid = 1'b1; r1_valid = 1'b1;
        smp();
        n_cmp++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_tie: got rdy0=%b rdy1=%b, required 1 0", r0_ready, r1_ready);
        end
        exp_q.push_back(alu_model(r0_a, r0_b, r0_fun, r0_sign));
        exp_id_q.push_back(1'b0);
        adv();
        r0_valid = 1'b0;
        smp();
        adv();
        smp();
        adv();
        smp();
        n_cmp++;
        if (r1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_r1_served: got rdy1=%b, required 1", r1_ready);
        end
        exp_q.push_back(alu_model(r1_a, r1_b, r1_fun, r1_sign));
        exp_id_q.push_back(1'b1);
        adv();
        r1_valid = 1'b0;
        smp();
        drain("rst");
    endtask

    task automatic test_non_winner_rready();
        adv();
        rand_req(r0_a, r0_b, r0_fun, r0_sign);
        r0_valid = 1'b1; r0_rready = 1'b0; r1_rready = 1'b1;
        smp();
        n_cmp++;
        if (r0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL nw_accept: got rdy0=%b, required 1", r0_ready);
        end
        exp_q.push_back(alu_model(r0_a, r0_b, r0_fun, r0_sign));
        exp_id_q.push_back(1'b0);
        adv();
        r0_valid = 1'b0;
        smp();
        for (int i = 0; i < 3; i++) begin
            adv();
            smp();
            n_cmp++;
            if (state_dbg !== RESP || r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL nw_hold: got state=%0d rv0=%b rv1=%b, required RESP 1 0",
                         state_dbg, r0_rvalid, r1_rvalid);
            end
        end
        adv();
        r0_rready = 1'b1;
        smp();
        drain("nw");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_fun = '0; r0_sign = 1'b0; r0_rready = 1'b0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_fun = '0; r1_sign = 1'b0; r1_rready = 1'b0;
        test_reset();
        test_single();
        test_tie_after_reset();
        test_contention();
        test_backpressure();
        test_reset_mid_issue();
        test_non_winner_rready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
